// File: rtl/cell_window_builder.sv
// Raster pixel stream to 3x3 cell windows using two line buffers; out_cell packs pixelMatrix[i][j] at bits [(i*3+j)*24 +: 24].
// Optional SOF_RESYNC_EN: in_sof forces the accepted pixel to (0,0) and adds a sticky sof_err output.
module cell_window_builder #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic         clock,
    input  logic         resetN,
    input  logic [23:0]  in_pixel,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_sof,
    output logic [215:0] out_cell,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_eol,
    output logic         out_eof
`ifdef SOF_RESYNC_EN
    ,
    output logic         sof_err
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]  col_q, col_d, pos_col;
    logic [RW-1:0]  row_q, row_d, pos_row;
    logic [23:0]    lb0_mem [IMG_W];
    logic [23:0]    lb1_mem [IMG_W];
    logic [23:0]    lb0_rd, lb1_rd;
    logic [23:0]    win_q [3][3];
    logic [23:0]    win_d [3][3];
    logic [215:0]   cell_d;
    logic [215:0]   out_cell_q;
    logic           out_valid_q, out_eol_q, out_eof_q;
    logic           accept, emit, resync;

    // Valid/ready: a transfer happens on a rising edge where valid && ready; the
    // single output register frees itself in the same cycle it is drained.
    assign in_ready = resetN && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

`ifdef SOF_RESYNC_EN
    logic sof_err_q;
    assign resync  = accept && in_sof;
    assign sof_err = sof_err_q;
`else
    logic unused_sof;
    assign unused_sof = in_sof;
    assign resync     = 1'b0;
`endif

    assign pos_col = resync ? '0 : col_q;
    assign pos_row = resync ? '0 : row_q;
    assign lb0_rd  = lb0_mem[pos_col];
    assign lb1_rd  = lb1_mem[pos_col];
    assign emit    = accept && (pos_row >= ROW_TWO) && (pos_col >= COL_TWO);

    always_comb begin
        win_d = win_q;
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            for (int i = 0; i < 3; i++) begin
                win_d[i][2] = win_q[i][1];
                win_d[i][1] = win_q[i][0];
            end
            win_d[0][0] = in_pixel;
            win_d[1][0] = lb0_rd;
            win_d[2][0] = lb1_rd;
            if (pos_col == COL_LAST) begin
                col_d = '0;
                row_d = (pos_row == ROW_LAST) ? '0 : pos_row + 1'b1;
            end else begin
                col_d = pos_col + 1'b1;
                row_d = pos_row;
            end
        end
    end

    always_comb begin
        cell_d = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                cell_d[(i*3+j)*24 +: 24] = win_d[i][j];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            col_q       <= '0;
            row_q       <= '0;
            out_cell_q  <= '0;
            out_valid_q <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                for (int j = 0; j < 3; j++) begin
                    win_q[i][j] <= '0;
                end
            end
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            win_q <= win_d;
            if (emit) begin
                out_cell_q  <= cell_d;
                out_valid_q <= 1'b1;
                out_eol_q   <= (pos_col == COL_LAST);
                out_eof_q   <= (pos_col == COL_LAST) && (pos_row == ROW_LAST);
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    // Line buffers hold no reset; each row is rewritten before it is read back.
    always_ff @(posedge clock) begin
        if (accept) begin
            lb1_mem[pos_col] <= lb0_rd;
            lb0_mem[pos_col] <= in_pixel;
        end
    end

`ifdef SOF_RESYNC_EN
    always_ff @(posedge clock) begin
        if (!resetN) begin
            sof_err_q <= 1'b0;
        end else if (resync && ((col_q != '0) || (row_q != '0))) begin
            sof_err_q <= 1'b1;
        end
    end
`endif

    assign out_cell  = out_cell_q;
    assign out_valid = out_valid_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;

endmodule

// File: tb/tb_cell_window_builder.sv
// Directed bench for cell_window_builder on a 5x4 image; pixels are {row, col, frame}.
// Build with +define+SOF_RESYNC_EN to also exercise the start-of-frame resync.
module tb_cell_window_builder;

    localparam int W = 5;
    localparam int H = 4;

    logic         clock = 1'b0;
    logic         resetN;
    logic [23:0]  in_pixel;
    logic         in_valid;
    logic         in_ready;
    logic         in_sof;
    logic [215:0] out_cell;
    logic         out_valid;
    logic         out_ready;
    logic         out_eol;
    logic         out_eof;
`ifdef SOF_RESYNC_EN
    logic         sof_err;
`endif

    cell_window_builder #(.IMG_W(W), .IMG_H(H)) dut (
        .clock     (clock),
        .resetN    (resetN),
        .in_pixel  (in_pixel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sof    (in_sof),
        .out_cell  (out_cell),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_eol   (out_eol),
        .out_eof   (out_eof)
`ifdef SOF_RESYNC_EN
        ,
        .sof_err   (sof_err)
`endif
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int cells_seen = 0;
    int eol_cnt = 0;
    int eof_cnt = 0;
    int acc_cnt = 0;
    int m_row = 0;
    int m_col = 0;
    int m_frame = 0;
    logic [217:0] exp_q[$];
    logic [217:0] last_exp;
    logic [215:0] held;

    task automatic checkv(input string tag, input logic [217:0] obs, input logic [217:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkp(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [217:0] mk_exp(input int r, input int c, input int f);
        logic [215:0] cl;
        logic eol, eof;
        cl = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                cl[(i*3+j)*24 +: 24] = {8'(r - i), 8'(c - j), 8'(f)};
            end
        end
        eol = (c == W - 1);
        eof = eol && (r == H - 1);
        return {cl, eol, eof};
    endfunction

    // One clock: drive, sample handshakes before the edge, check 1-cycle latency after it.
    task automatic cycle(input logic v, input logic ordy, input logic sof);
        logic acc, emit;
        logic [217:0] e;
        in_valid  = v;
        out_ready = ordy;
        in_sof    = sof;
        in_pixel  = {8'(m_row), 8'(m_col), 8'(m_frame)};
        #2;
        acc  = in_valid && in_ready;
        emit = 1'b0;
        if (out_valid && out_ready) begin
            cells_seen++;
            if (out_eol) eol_cnt++;
            if (out_eof) eof_cnt++;
            if (exp_q.size() == 0) begin
                checki("unexpected_cell", 1, 0);
            end else begin
                e = exp_q.pop_front();
                checkv("cell_handshake", {out_cell, out_eol, out_eof}, e);
            end
        end
        if (acc) begin
            acc_cnt++;
            if (m_row >= 2 && m_col >= 2) begin
                emit = 1'b1;
                last_exp = mk_exp(m_row, m_col, m_frame);
                exp_q.push_back(last_exp);
            end
            if (m_col == W - 1) begin
                m_col = 0;
                if (m_row == H - 1) begin
                    m_row = 0;
                    m_frame++;
                end else begin
                    m_row++;
                end
            end else begin
                m_col++;
            end
        end
        @(posedge clock);
        #1;
        if (emit) begin
            check1("latency_valid", out_valid, 1'b1);
            checkv("latency_cell", {out_cell, out_eol, out_eof}, last_exp);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 10 && exp_q.size() != 0; n++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        checki("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        int base;
        resetN    = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        out_ready = 1'b1;
        in_pixel  = '0;
        repeat (3) @(posedge clock);
        #1;
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_out_eol", out_eol, 1'b0);
        check1("rst_out_eof", out_eof, 1'b0);
        checkv("rst_out_cell", {out_cell, 2'b00}, '0);
        check1("rst_in_ready", in_ready, 1'b0);
`ifdef SOF_RESYNC_EN
        check1("rst_sof_err", sof_err, 1'b0);
`endif
        resetN = 1'b1;
        #1;
        check1("post_rst_in_ready", in_ready, 1'b1);

        // Full frame, continuous valid
        base = cells_seen;
        for (int p = 0; p < 20; p++) begin
            cycle(1'b1, 1'b1, 1'b0);
            if (p == 12) begin
                checkp("first_c11", out_cell[4*24 +: 24], 24'h010100);
                checkp("first_c00", out_cell[0*24 +: 24], 24'h020200);
                checkp("first_c22", out_cell[8*24 +: 24], 24'h000000);
            end
            if (p == 17) begin
                checkp("wrap_c00", out_cell[0*24 +: 24], 24'h030200);
                checkp("wrap_c20", out_cell[6*24 +: 24], 24'h010200);
                checkp("wrap_c01", out_cell[1*24 +: 24], 24'h030100);
                checkp("wrap_c02", out_cell[2*24 +: 24], 24'h030000);
            end
        end
        drain();
        checki("frame0_cells", cells_seen - base, 6);
        checki("frame0_eol", eol_cnt, 2);
        checki("frame0_eof", eof_cnt, 1);

        // Backpressure while cell 1 is valid
        base = cells_seen;
        for (int p = 0; p < 13; p++) cycle(1'b1, 1'b1, 1'b0);
        held = out_cell;
        for (int s = 0; s < 4; s++) begin
            cycle(1'b1, 1'b0, 1'b0);
            check1("stall_in_ready", in_ready, 1'b0);
            check1("stall_out_valid", out_valid, 1'b1);
            checkv("stall_cell_stable", {out_cell, 2'b00}, {held, 2'b00});
        end
        for (int p = 0; p < 7; p++) cycle(1'b1, 1'b1, 1'b0);
        drain();
        checki("bp_cells", cells_seen - base, 6);

        // Random in_valid gaps over two frames
        base = cells_seen;
        acc_cnt = 0;
        for (int n = 0; n < 400 && acc_cnt < 40; n++) begin
            cycle(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        end
        checki("gap_accepted", acc_cnt, 40);
        drain();
        checki("gap_cells", cells_seen - base, 12);

        // Synchronous reset mid-frame
        for (int p = 0; p < 12; p++) cycle(1'b1, 1'b1, 1'b0);
        resetN   = 1'b0;
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        check1("midrst_out_valid", out_valid, 1'b0);
        checki("midrst_no_pending", exp_q.size(), 0);
        resetN  = 1'b1;
        m_row   = 0;
        m_col   = 0;
        m_frame = 5;
        base = cells_seen;
        for (int p = 0; p < 20; p++) cycle(1'b1, 1'b1, 1'b0);
        drain();
        checki("post_rst_cells", cells_seen - base, 6);

`ifdef SOF_RESYNC_EN
        check1("sof_err_clear", sof_err, 1'b0);
        for (int p = 0; p < 7; p++) cycle(1'b1, 1'b1, 1'b0);
        m_row   = 0;
        m_col   = 0;
        m_frame = 9;
        base = cells_seen;
        cycle(1'b1, 1'b1, 1'b1);
        check1("sof_err_set", sof_err, 1'b1);
        for (int p = 0; p < 19; p++) cycle(1'b1, 1'b1, 1'b0);
        drain();
        checki("sof_cells", cells_seen - base, 6);
        check1("sof_err_sticky", sof_err, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
